rand_coord_arbiter: RTL and testbench
=====================================

# rand_coord_arbiter

Shares one 4-bit maximal-length LFSR between several requesters that need random Go-board coordinates, e.g. the automated move picker and the demo/self-play sequencer. A round-robin arbiter grants one requester at a time. A small FSM steps the LFSR and rejection-samples a legal row, then a legal column, and returns the pair with a one-cycle acknowledge. It sits between the game-control logic and the random source, replacing ad-hoc button-strobed capture of raw LFSR output.

## Interface
- BOARD_SIZE, 9: board dimension; legal 2..15; coordinates are 0..BOARD_SIZE-1.
- NREQ, 2: number of requesters; legal 1..8.
- CLK  in  1  single clock; all logic on rising edge.
- RSTN  in  1  reset, asynchronous, active-low.
- REQ  in  NREQ  per-requester level request; held until the matching ACK.
- ACK  out  NREQ  one-hot, one-cycle pulse; ROW/COL are valid in that cycle.
- ROW  out  4  granted row, held until the next ACK.
- COL  out  4  granted column, held until the next ACK.
- BUSY  out  1  high in every state except IDLE.

## Operation
- LFSR: Fibonacci, x^4+x^3+1, next = {q[2:0], q[3]^q[2]}, seed 4'b0001, period 15, never 0.
- Sequence from seed: 1,2,4,9,3,6,13,10,5,11,7,15,14,12,8, then it repeats.
- Sample mapping: current q is accepted iff q <= BOARD_SIZE; coordinate = q-1 (4-bit, no overflow). Every value is reached within 15 steps.
- FSM states: IDLE, DRAW_ROW, DRAW_COL, DONE.
- IDLE: if any REQ bit is high, grant the first set bit at or after the priority pointer (wrapping), latch the grant index, go to DRAW_ROW. Otherwise stay.
- DRAW_ROW: step the LFSR every cycle. If the current q is accepted, latch the row and go to DRAW_COL; otherwise stay.
- DRAW_COL: same procedure, latching the column, then go to DONE.
- DONE: ACK[grant]=1 for exactly this cycle; ROW/COL update on entry to DONE. Priority pointer becomes grant+1 mod NREQ. Return to IDLE.
- REQ dropping mid-draw: no abort; the draw completes and ACK still pulses.
- REQ bits for non-granted requesters are ignored until IDLE.
- Reset, including mid-draw: state IDLE, ACK 0, ROW 0, COL 0, BUSY 0, LFSR 4'b0001, pointer 0. No ACK is issued for an aborted draw.

## Timing
- REQ sampled at edge E in IDLE. Best case: ACK is high in the cycle after edge E+3; worst case: E+3+2*14.
- ACK drops at the following edge and the FSM is in IDLE.
- The next REQ sample happens at the edge after that, so there is a minimum of 1 IDLE cycle between grants.
- A requester that registers ACK and deasserts REQ at the next edge is never granted twice.
- All outputs are registered; there are no combinational paths from REQ to ACK.

## Configuration
- RAND_COORD_FREERUN_EN defined: the LFSR steps on every cycle in every state. Draw results depend on request timing, giving entropy from human-timed events. Accept/reject rules are unchanged.
- Not defined: the LFSR steps only in DRAW_ROW/DRAW_COL. Results are a deterministic function of the request count since reset. The test plan values assume this mode.

## Structure
- Package rand_coord_pkg holds:
  - the state enum;
  - LFSR_W=4;
  - LFSR_SEED=4'b0001;
  - the tap positions.
- Sub-module lfsr4_step contains:
  - the 4-bit register;
  - step-enable input;
  - async active-low reset to the seed;
  - output q.
- Arbiter pointer, FSM and accept compare live in the top.

## Test plan
- Reset, then REQ=01 held: first ACK=01 with ROW=0, COL=1, at edge E+3. Three further requests give (3,8), (2,5), (4,6).
- The fourth request takes 3 row-draw cycles and 2 column-draw cycles, giving ACK at E+6.
- REQ=11 held continuously: ACK alternates 01,10,01,10; there is exactly 1 IDLE cycle between pulses.
- BOARD_SIZE=2: every ROW/COL is in 0..1; no request takes more than 29 cycles to ACK.
- REQ dropped 1 cycle after the grant: ACK still pulses once. With REQ then low, no further ACK occurs and BUSY stays 0.
- RSTN pulsed low during DRAW_COL: no ACK; all outputs 0. The next request returns (0,1) again.

Source files
------------

// File: rtl/rand_coord_arbiter_pkg.sv
// Shared types and constants for the random Go-coordinate arbiter and its LFSR.
package rand_coord_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DRAW_ROW = 2'd1,
        DRAW_COL = 2'd2,
        DONE     = 2'd3
    } state_t;

    localparam int             LFSR_W    = 4;
    localparam logic [LFSR_W-1:0] LFSR_SEED = 4'b0001;

    // Feedback taps for x^4 + x^3 + 1 in a left-shifting Fibonacci register.
    localparam int TAP_HI = 3;
    localparam int TAP_LO = 2;

endpackage

// File: rtl/rand_coord_arbiter_if.sv
// Request/acknowledge bus between game-control requesters and the coordinate arbiter.
interface rand_coord_arbiter_if #(
    parameter int NREQ = 2
);
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] ack;
    logic [3:0]      row;
    logic [3:0]      col;
    logic            busy;

    modport master (output req, input ack, input row, input col, input busy);
    modport slave  (input req, output ack, output row, output col, output busy);
endinterface

// File: rtl/rand_coord_arbiter_lfsr4_step.sv
// 4-bit maximal-length Fibonacci LFSR (period 15) with step enable; resets to the seed.
module lfsr4_step
    import rand_coord_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              step_en,
    output logic [LFSR_W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= LFSR_SEED;
        end else if (step_en) begin
            q <= {q[LFSR_W-2:0], q[TAP_HI] ^ q[TAP_LO]};
        end
    end

endmodule

// File: rtl/rand_coord_arbiter.sv
// Round-robin arbiter granting a shared LFSR; rejection-samples a legal row then column.
// Define RAND_COORD_FREERUN_EN to let the LFSR step every cycle for timing-derived entropy.
module rand_coord_arbiter
    import rand_coord_pkg::*;
#(
    parameter int BOARD_SIZE = 9,
    parameter int NREQ       = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    rand_coord_arbiter_if.slave  bus
);

    localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t            state;
    logic [IDX_W-1:0]  ptr;
    logic [IDX_W-1:0]  grant;
    logic [IDX_W-1:0]  pick;
    logic              pick_vld;
    logic              step_en;
    logic              accept;
    logic [LFSR_W-1:0] q;
    logic [LFSR_W-1:0] coord;
    logic [LFSR_W-1:0] row_tmp;

`ifdef RAND_COORD_FREERUN_EN
    assign step_en = 1'b1;
`else
    assign step_en = (state == DRAW_ROW) || (state == DRAW_COL);
`endif

    lfsr4_step u_lfsr (
        .clk     (clk),
        .rst_n   (rst_n),
        .step_en (step_en),
        .q       (q)
    );

    // q is never 0, so q-1 cannot underflow and q <= BOARD_SIZE maps onto 0..BOARD_SIZE-1.
    assign accept = (int'(q) <= BOARD_SIZE);
    assign coord  = q - LFSR_W'(1);

    // First requester at or after the priority pointer, wrapping around.
    always_comb begin
        int j;
        j        = 0;
        pick     = '0;
        pick_vld = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            j = (int'(ptr) + i) % NREQ;
            if (!pick_vld && bus.req[j]) begin
                pick     = IDX_W'(j);
                pick_vld = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= '0;
            grant    <= '0;
            row_tmp  <= '0;
            bus.ack  <= '0;
            bus.row  <= '0;
            bus.col  <= '0;
            bus.busy <= 1'b0;
        end else begin
            bus.ack <= '0;
            case (state)
                IDLE: begin
                    // Skip the sample while ACK is out so the acked requester can drop REQ.
                    if (pick_vld && (bus.ack == '0)) begin
                        grant    <= pick;
                        state    <= DRAW_ROW;
                        bus.busy <= 1'b1;
                    end
                end
                DRAW_ROW: begin
                    if (accept) begin
                        row_tmp <= coord;
                        state   <= DRAW_COL;
                    end
                end
                DRAW_COL: begin
                    if (accept) begin
                        bus.row <= row_tmp;
                        bus.col <= coord;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    bus.ack[grant] <= 1'b1;
                    ptr            <= (grant == IDX_W'(NREQ - 1)) ? '0 : grant + 1'b1;
                    state          <= IDLE;
                    bus.busy       <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rand_coord_arbiter.sv
// Directed bench: a 9x9 instance and a 2x2 instance share clock and reset.
module tb_rand_coord_arbiter;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    rand_coord_arbiter_if #(.NREQ(2)) bus  ();
    rand_coord_arbiter_if #(.NREQ(2)) bus2 ();

    rand_coord_arbiter #(.BOARD_SIZE(9), .NREQ(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    rand_coord_arbiter #(.BOARD_SIZE(2), .NREQ(2)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [1:0] ack_of(input int w);
        return (w == 0) ? bus.ack : bus2.ack;
    endfunction
    function automatic logic [3:0] row_of(input int w);
        return (w == 0) ? bus.row : bus2.row;
    endfunction
    function automatic logic [3:0] col_of(input int w);
        return (w == 0) ? bus.col : bus2.col;
    endfunction
    function automatic logic busy_of(input int w);
        return (w == 0) ? bus.busy : bus2.busy;
    endfunction

    task automatic set_req(input int w, input logic [1:0] m);
        if (w == 0) bus.req = m;
        else        bus2.req = m;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Counts edges (sampling #1 after each) until an ACK appears or the limit runs out.
    task automatic wait_ack(input int w, input int limit, output int cnt);
        cnt = 0;
        while (cnt < limit) begin
            @(posedge clk); #1;
            cnt++;
            if (ack_of(w) != 2'b00) break;
        end
    endtask

    task automatic do_req(input int w, input logic [1:0] m, input logic [1:0] e_ack,
                          input logic [3:0] e_row, input logic [3:0] e_col, input int e_lat);
        int cnt;
        set_req(w, m);
        wait_ack(w, 40, cnt);
        set_req(w, 2'b00);
        check("req_ack", 32'(ack_of(w)), 32'(e_ack));
        check("req_row", 32'(row_of(w)), 32'(e_row));
        check("req_col", 32'(col_of(w)), 32'(e_col));
        check("req_lat", 32'(cnt), 32'(e_lat));
        @(posedge clk); #1;
        check("ack_drop", 32'(ack_of(w)), 32'd0);
        check("busy_idle", 32'(busy_of(w)), 32'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.req  = 2'b00;
        bus2.req = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [1:0] h_ack [4];
        logic [3:0] h_row [4];
        logic [3:0] h_col [4];
        int         h_lat [4];
        int         cnt;
        int         nz;

        total = 0;
        bad   = 0;
        clk   = 1'b0;
        rst_n = 1'b0;
        bus.req  = 2'b00;
        bus2.req = 2'b00;

        // Reset state of both instances.
        repeat (2) @(posedge clk);
        #1;
        check("rst_ack",   32'(bus.ack),   32'd0);
        check("rst_row",   32'(bus.row),   32'd0);
        check("rst_col",   32'(bus.col),   32'd0);
        check("rst_busy",  32'(bus.busy),  32'd0);
        check("rst2_ack",  32'(bus2.ack),  32'd0);
        check("rst2_busy", 32'(bus2.busy), 32'd0);
        rst_n = 1'b1;

        // Four single-requester draws: LFSR 1,2 | 4,9 | 3,6 | 13,10,5,11,7.
        do_req(0, 2'b01, 2'b01, 4'd0, 4'd1, 4);
        do_req(0, 2'b01, 2'b01, 4'd3, 4'd8, 4);
        do_req(0, 2'b01, 2'b01, 4'd2, 4'd5, 4);
        do_req(0, 2'b01, 2'b01, 4'd4, 4'd6, 7);

        // Both requesting continuously after reset: grants alternate from requester 0.
        do_reset();
        h_ack = '{2'b01, 2'b10, 2'b01, 2'b10};
        h_row = '{4'd0, 4'd3, 4'd2, 4'd4};
        h_col = '{4'd1, 4'd8, 4'd5, 4'd6};
        h_lat = '{4, 3, 3, 6};
        bus.req = 2'b11;
        for (int k = 0; k < 4; k++) begin
            wait_ack(0, 40, cnt);
            if (k == 3) bus.req = 2'b00;
            check("rr_ack", 32'(bus.ack), 32'(h_ack[k]));
            check("rr_row", 32'(bus.row), 32'(h_row[k]));
            check("rr_col", 32'(bus.col), 32'(h_col[k]));
            check("rr_lat", 32'(cnt),     32'(h_lat[k]));
            @(posedge clk); #1;
            check("rr_gap_ack",  32'(bus.ack),  32'd0);
            check("rr_gap_busy", 32'(bus.busy), 32'd0);
            if (k < 3) begin
                @(posedge clk); #1;
                check("rr_regrant_busy", 32'(bus.busy), 32'd1);
            end
        end

        // Request dropped right after the grant: draw 15,14,12,8 -> row 7, then 1 -> col 0.
        bus.req = 2'b01;
        @(posedge clk); #1;
        check("drop_busy", 32'(bus.busy), 32'd1);
        bus.req = 2'b00;
        wait_ack(0, 40, cnt);
        check("drop_ack", 32'(bus.ack), 32'(2'b01));
        check("drop_row", 32'(bus.row), 32'd7);
        check("drop_col", 32'(bus.col), 32'd0);
        check("drop_lat", 32'(cnt + 1), 32'd7);
        nz = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (bus.ack != 2'b00 || bus.busy) nz++;
        end
        check("drop_quiet", 32'(nz), 32'd0);

        // Reset asserted while drawing the column (row taken from q=2, column pending on q=4).
        bus.req = 2'b01;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        bus.req = 2'b00;
        #1;
        check("mid_rst_ack",  32'(bus.ack),  32'd0);
        check("mid_rst_row",  32'(bus.row),  32'd0);
        check("mid_rst_col",  32'(bus.col),  32'd0);
        check("mid_rst_busy", 32'(bus.busy), 32'd0);
        nz = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (bus.ack != 2'b00) nz++;
        end
        check("mid_rst_noack", 32'(nz), 32'd0);
        rst_n = 1'b1;
        do_req(0, 2'b01, 2'b01, 4'd0, 4'd1, 4);

        // 2x2 board: only q=1 and q=2 are legal; later draws reject 13 values before row.
        do_req(1, 2'b01, 2'b01, 4'd0, 4'd1, 4);
        do_req(1, 2'b01, 2'b01, 4'd0, 4'd1, 17);
        do_req(1, 2'b10, 2'b10, 4'd0, 4'd1, 17);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
